// File: rtl/whack_a_mole_pkg.sv
// rtl/whack_a_mole_pkg.sv - shared types, LFSR step and widths for the whack-a-mole controller
package whack_a_mole_pkg;

  typedef enum logic [1:0] {IDLE, MOLE_DOWN, MOLE_UP, GAMEOVER} state_t;

  localparam int LFSR_W = 16;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond tick divider, held at zero while disabled
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic reset_button_pressed,
  input  logic enable,
  output logic ms_tick
);

  localparam int CNT_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  logic [CNT_W-1:0] cnt;

  assign ms_tick = enable && (cnt == CNT_W'(CLKS_PER_MS - 1));

  always_ff @(posedge clk or posedge reset_button_pressed) begin
    if (reset_button_pressed) begin
      cnt <= '0;
    end else if (!enable || ms_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/whack_a_mole_multi_fsm.sv
// rtl/whack_a_mole_multi_fsm.sv - multi-mole game FSM with LFSR mole choice, scoring and levels
module whack_a_mole_multi_fsm
  import whack_a_mole_pkg::*;
#(
  parameter int NUM_MOLES    = 4,
  parameter int MOLE_UP_MS   = 1000,
  parameter int MOLE_DOWN_MS = 500,
  parameter int MIN_UP_MS    = 300,
  parameter int STEP_MS      = 100,
  parameter int LEVEL_HITS   = 5,
  parameter int MAX_TIMER_MS = 20000,
  parameter int CLKS_PER_MS  = 50000,
  parameter int SCORE_W      = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                                  clk,
  input  logic                                  reset_button_pressed,
  input  logic                                  start_button_pressed,
  input  logic [NUM_MOLES-1:0]                  whack_buttons,
  input  logic [$clog2(MAX_TIMER_MS+1)-1:0]     timer_milliseconds,
  output logic [NUM_MOLES-1:0]                  mole_onehot,
  output logic                                  game_in_progress,
  output logic                                  game_over,
  output logic                                  hit_pulse,
  output logic [SCORE_W-1:0]                    score,
  output logic [SCORE_W-1:0]                    misses,
  output logic [LEVEL_W-1:0]                    level
);

  localparam int IDX_W  = $clog2(NUM_MOLES);
  localparam int UP_W   = $clog2(MOLE_UP_MS + 1);
  localparam int PH_MAX = (MOLE_UP_MS > MOLE_DOWN_MS) ? MOLE_UP_MS : MOLE_DOWN_MS;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int LH_W   = $clog2(LEVEL_HITS + 1);
  localparam logic [PH_W-1:0]  DOWN_LOAD = PH_W'(MOLE_DOWN_MS - 1);
  localparam logic [IDX_W:0]   SEL_N     = (IDX_W+1)'(NUM_MOLES);

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       next_idx;
  logic [IDX_W:0]         sel;
  logic [UP_W-1:0]        up_ms;
  logic [UP_W-1:0]        up_dec;
  logic [PH_W-1:0]        phase;
  logic [LH_W-1:0]        lvl_hits;
  logic [LFSR_W-1:0]      lfsr;
  logic                   start_prev;
  logic                   start_edge;
  logic [NUM_MOLES-1:0]   whack_prev;
  logic [NUM_MOLES-1:0]   whack_edge;
  logic [NUM_MOLES-1:0]   idx_mask;
  logic                   tick_en;
  logic                   ms_tick;
  logic                   expire;
  logic                   timer_zero;
  logic                   hit;
  logic                   wrong;

  ms_tick_gen #(.CLKS_PER_MS(CLKS_PER_MS)) u_ms_tick (
    .clk                  (clk),
    .reset_button_pressed (reset_button_pressed),
    .enable               (tick_en),
    .ms_tick              (ms_tick)
  );

  assign tick_en          = (state == MOLE_DOWN) || (state == MOLE_UP);
  assign expire           = ms_tick && (phase == '0);
  assign timer_zero       = (timer_milliseconds == '0);
  assign idx_mask         = NUM_MOLES'(1) << idx;
  assign hit              = |(whack_edge & idx_mask);
  assign wrong            = |(whack_edge & ~idx_mask);
  assign mole_onehot      = (state == MOLE_UP) ? idx_mask : '0;
  assign game_in_progress = tick_en;
  assign game_over        = (state == GAMEOVER);

  // Never repeat the previous mole: fold out-of-range values, then step past a repeat.
  always_comb begin
    sel = {1'b0, lfsr[IDX_W-1:0]};
    if (sel >= SEL_N) sel = sel - SEL_N;
    if (sel[IDX_W-1:0] == idx) sel = (sel == SEL_N - (IDX_W+1)'(1)) ? '0 : sel + (IDX_W+1)'(1);
    next_idx = sel[IDX_W-1:0];
  end

  always_comb begin
    if (int'(up_ms) >= MIN_UP_MS + STEP_MS) up_dec = up_ms - UP_W'(STEP_MS);
    else                                   up_dec = UP_W'(MIN_UP_MS);
  end

  always_ff @(posedge clk or posedge reset_button_pressed) begin
    if (reset_button_pressed) begin
      start_prev <= 1'b0;
      start_edge <= 1'b0;
      whack_prev <= '0;
      whack_edge <= '0;
      lfsr       <= LFSR_SEED;
    end else begin
      start_prev <= start_button_pressed;
      start_edge <= start_button_pressed & ~start_prev;
      whack_prev <= whack_buttons;
      whack_edge <= whack_buttons & ~whack_prev;
      lfsr       <= lfsr_next(lfsr);
    end
  end

  always_ff @(posedge clk or posedge reset_button_pressed) begin
    if (reset_button_pressed) begin
      state     <= IDLE;
      idx       <= '0;
      score     <= '0;
      misses    <= '0;
      level     <= '0;
      hit_pulse <= 1'b0;
      up_ms     <= UP_W'(MOLE_UP_MS);
      lvl_hits  <= '0;
      phase     <= '0;
    end else begin
      hit_pulse <= 1'b0;
      case (state)
        IDLE, GAMEOVER: begin
          if (start_edge) begin
            state    <= MOLE_DOWN;
            score    <= '0;
            misses   <= '0;
            level    <= '0;
            up_ms    <= UP_W'(MOLE_UP_MS);
            lvl_hits <= '0;
            phase    <= DOWN_LOAD;
          end
        end
        MOLE_DOWN: begin
          if (timer_zero) begin
            state <= GAMEOVER;
          end else if (expire) begin
            idx   <= next_idx;
            state <= MOLE_UP;
            phase <= PH_W'(up_ms - UP_W'(1));
          end else if (ms_tick) begin
            phase <= phase - PH_W'(1);
          end
        end
        MOLE_UP: begin
          if (timer_zero) begin
            state <= GAMEOVER;
          end else if (hit) begin
            if (score != '1) score <= score + SCORE_W'(1);
            hit_pulse <= 1'b1;
            state     <= MOLE_DOWN;
            phase     <= DOWN_LOAD;
            if (lvl_hits == LH_W'(LEVEL_HITS - 1)) begin
              lvl_hits <= '0;
              up_ms    <= up_dec;
              if (level != LEVEL_MAX) level <= level + 4'd1;
            end else begin
              lvl_hits <= lvl_hits + LH_W'(1);
            end
          end else if (wrong) begin
            // The mole stays up; a window that expires now fires on the next tick.
            if (misses != '1) misses <= misses + SCORE_W'(1);
            if (ms_tick && phase != '0) phase <= phase - PH_W'(1);
          end else if (expire) begin
            if (misses != '1) misses <= misses + SCORE_W'(1);
            state <= MOLE_DOWN;
            phase <= DOWN_LOAD;
          end else if (ms_tick) begin
            phase <= phase - PH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_whack_a_mole_multi_fsm.sv
// tb/tb_whack_a_mole_multi_fsm.sv - randomized and directed bench against a behavioural game model
module tb_whack_a_mole_multi_fsm;

  localparam int N     = 4;
  localparam int CPM   = 4;
  localparam int UP0   = 5;
  localparam int DOWN  = 3;
  localparam int MINUP = 3;
  localparam int STEP  = 1;
  localparam int LH    = 2;
  localparam int TW    = $clog2(20000 + 1);
  localparam int IDXW  = $clog2(N);
  localparam int M_IDLE = 0, M_DOWN = 1, M_UP = 2, M_OVER = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  whacks;
  logic [TW-1:0] timer_ms;
  logic [N-1:0]  mole_onehot;
  logic          game_in_progress, game_over, hit_pulse;
  logic [7:0]    score, misses;
  logic [3:0]    level;
  logic [N+18:0] dut_pack;

  int vectors = 0;
  int miscompares = 0;

  int m_mode, m_idx, m_score, m_misses, m_level, m_up, m_hits_lvl, m_ticks_left, m_div;
  bit m_hit, m_prev_start, m_pend_start;
  logic [15:0]  m_lfsr;
  logic [N-1:0] m_prev_wh, m_pend_wh;

  whack_a_mole_multi_fsm #(
    .NUM_MOLES(N), .MOLE_UP_MS(UP0), .MOLE_DOWN_MS(DOWN), .MIN_UP_MS(MINUP),
    .STEP_MS(STEP), .LEVEL_HITS(LH), .MAX_TIMER_MS(20000), .CLKS_PER_MS(CPM),
    .SCORE_W(8), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset_button_pressed(rst), .start_button_pressed(start),
    .whack_buttons(whacks), .timer_milliseconds(timer_ms),
    .mole_onehot(mole_onehot), .game_in_progress(game_in_progress),
    .game_over(game_over), .hit_pulse(hit_pulse), .score(score),
    .misses(misses), .level(level)
  );

  always #5 clk = ~clk;

  assign dut_pack = {mole_onehot, game_in_progress, game_over, hit_pulse, score, misses, level};

  function automatic void model_reset();
    m_mode = M_IDLE; m_idx = 0; m_score = 0; m_misses = 0; m_level = 0; m_hit = 0;
    m_up = UP0; m_hits_lvl = 0; m_ticks_left = 0; m_div = 0; m_lfsr = 16'hACE1;
    m_prev_start = 0; m_pend_start = 0; m_prev_wh = '0; m_pend_wh = '0;
  endfunction

  function automatic logic [N-1:0] model_mole();
    return (m_mode == M_UP) ? N'(1 << m_idx) : '0;
  endfunction

  function automatic logic [N+18:0] model_pack();
    return {model_mole(), (m_mode == M_DOWN || m_mode == M_UP), (m_mode == M_OVER), m_hit,
            8'(m_score), 8'(m_misses), 4'(m_level)};
  endfunction

  function automatic void new_game();
    m_mode = M_DOWN; m_score = 0; m_misses = 0; m_level = 0; m_up = UP0;
    m_hits_lvl = 0; m_ticks_left = DOWN;
  endfunction

  // One clock of the game rules: edges act one cycle after the button press.
  function automatic void model_clock();
    bit in_game, tick;
    int r;
    in_game = (m_mode == M_DOWN || m_mode == M_UP);
    tick = in_game && (m_div == CPM - 1);
    m_hit = 0;
    case (m_mode)
      M_IDLE, M_OVER: if (m_pend_start) new_game();
      M_DOWN: begin
        if (timer_ms == 0) m_mode = M_OVER;
        else if (tick) begin
          if (m_ticks_left == 1) begin
            r = int'(m_lfsr) % (1 << IDXW);
            if (r >= N) r -= N;
            if (r == m_idx) r = (r + 1) % N;
            m_idx = r; m_mode = M_UP; m_ticks_left = m_up;
          end else m_ticks_left--;
        end
      end
      M_UP: begin
        if (timer_ms == 0) m_mode = M_OVER;
        else if (m_pend_wh[m_idx]) begin
          if (m_score < 255) m_score++;
          m_hit = 1; m_hits_lvl++;
          if (m_hits_lvl == LH) begin
            m_hits_lvl = 0;
            if (m_level < 15) m_level++;
            m_up = (m_up - STEP < MINUP) ? MINUP : m_up - STEP;
          end
          m_mode = M_DOWN; m_ticks_left = DOWN;
        end else if (m_pend_wh != 0) begin
          if (m_misses < 255) m_misses++;
          if (tick && m_ticks_left > 1) m_ticks_left--;
        end else if (tick) begin
          if (m_ticks_left == 1) begin
            if (m_misses < 255) m_misses++;
            m_mode = M_DOWN; m_ticks_left = DOWN;
          end else m_ticks_left--;
        end
      end
      default: ;
    endcase
    m_div = in_game ? (m_div + 1) % CPM : 0;
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    m_pend_start = start && !m_prev_start;
    m_prev_start = start;
    m_pend_wh = whacks & ~m_prev_wh;
    m_prev_wh = whacks;
  endfunction

  task automatic step(input bit s, input logic [N-1:0] w, input int t);
    start = s; whacks = w; timer_ms = TW'(t);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; whacks = '0; timer_ms = TW'(100);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_mole(output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (mole_onehot != '0) ok = 1;
      else step(0, '0, 100);
    end
  endtask

  task automatic count_lit(output int lit);
    lit = 0;
    while (mole_onehot != '0 && lit < 100) begin
      lit++;
      step(0, '0, 100);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (dut_pack !== '0) begin
      miscompares++; $display("FAIL reset_state: got %h expected 0", dut_pack);
    end
  endtask

  task automatic test_first_mole();
    int zeros;
    step(1, '0, 100);
    step(0, '0, 100);
    vectors++;
    if (game_in_progress !== 1'b1) begin
      miscompares++; $display("FAIL enter_down: got %b expected 1", game_in_progress);
    end
    zeros = 0;
    while (mole_onehot == '0 && zeros < 100) begin
      zeros++;
      step(0, '0, 100);
    end
    vectors++;
    if (zeros != DOWN * CPM) begin
      miscompares++; $display("FAIL down_window: got %0d clks expected %0d", zeros, DOWN * CPM);
    end
    vectors++;
    if ($countones(mole_onehot) != 1 || mole_onehot !== model_mole()) begin
      miscompares++; $display("FAIL first_mole: got %b expected %b", mole_onehot, model_mole());
    end
  endtask

  task automatic test_timeout();
    int lit;
    bit ok;
    logic [N-1:0] prev;
    prev = mole_onehot;
    count_lit(lit);
    vectors++;
    if (lit != UP0 * CPM) begin
      miscompares++; $display("FAIL up_window: got %0d clks expected %0d", lit, UP0 * CPM);
    end
    vectors++;
    if (misses !== 8'd1 || score !== 8'd0) begin
      miscompares++; $display("FAIL timeout_miss: got misses %0d score %0d expected 1 0", misses, score);
    end
    wait_mole(ok);
    vectors++;
    if (!ok || mole_onehot === prev || mole_onehot !== model_mole()) begin
      miscompares++; $display("FAIL next_mole: got %b expected %b (previous %b)", mole_onehot, model_mole(), prev);
    end
  endtask

  task automatic test_hits();
    logic [N-1:0] w;
    bit ok;
    int lit;
    step(0, '0, 100);
    step(0, '0, 100);
    w = mole_onehot;
    step(0, w, 100);
    vectors++;
    if (hit_pulse !== 1'b0) begin
      miscompares++; $display("FAIL hit_early: got %b expected 0", hit_pulse);
    end
    step(0, w, 100);
    vectors++;
    if (hit_pulse !== 1'b1 || score !== 8'd1 || mole_onehot !== '0) begin
      miscompares++; $display("FAIL first_hit: got pulse %b score %0d mole %b expected 1 1 0", hit_pulse, score, mole_onehot);
    end
    step(0, '0, 100);
    wait_mole(ok);
    w = mole_onehot;
    step(0, w, 100);
    step(0, '0, 100);
    vectors++;
    if (!ok || score !== 8'd2 || level !== 4'd1) begin
      miscompares++; $display("FAIL second_hit: got score %0d level %0d expected 2 1", score, level);
    end
    wait_mole(ok);
    count_lit(lit);
    vectors++;
    if (!ok || lit != (UP0 - STEP) * CPM) begin
      miscompares++; $display("FAIL level1_window: got %0d clks expected %0d", lit, (UP0 - STEP) * CPM);
    end
  endtask

  task automatic test_level_floor();
    logic [N-1:0] w;
    bit ok;
    int lit;
    do_reset();
    step(1, '0, 100);
    step(0, '0, 100);
    for (int h = 1; h <= 6; h++) begin
      wait_mole(ok);
      w = mole_onehot;
      step(0, w, 100);
      step(0, '0, 100);
      vectors++;
      if (!ok || level !== 4'(h / 2)) begin
        miscompares++; $display("FAIL level_after_hit%0d: got %0d expected %0d", h, level, h / 2);
      end
    end
    wait_mole(ok);
    count_lit(lit);
    vectors++;
    if (!ok || lit != MINUP * CPM) begin
      miscompares++; $display("FAIL floor_window: got %0d clks expected %0d", lit, MINUP * CPM);
    end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] w, other;
    logic [7:0] s0, m0;
    bit ok;
    wait_mole(ok);
    w = mole_onehot; other = {w[N-2:0], w[N-1]};
    s0 = score; m0 = misses;
    step(0, w | other, 100);
    step(0, '0, 100);
    vectors++;
    if (!ok || score !== s0 + 8'd1 || misses !== m0) begin
      miscompares++; $display("FAIL hit_plus_wrong: got score %0d misses %0d expected %0d %0d", score, misses, s0 + 8'd1, m0);
    end
    wait_mole(ok);
    w = mole_onehot; other = {w[N-2:0], w[N-1]};
    m0 = misses;
    step(0, other, 100);
    step(0, '0, 100);
    vectors++;
    if (!ok || misses !== m0 + 8'd1 || mole_onehot !== w) begin
      miscompares++; $display("FAIL wrong_alone: got misses %0d mole %b expected %0d %b", misses, mole_onehot, m0 + 8'd1, w);
    end
  endtask

  task automatic test_gameover();
    logic [N-1:0] w;
    logic [7:0] s0;
    bit ok;
    wait_mole(ok);
    w = mole_onehot; s0 = score;
    step(0, w, 100);
    step(0, '0, 0);
    vectors++;
    if (!ok || game_over !== 1'b1 || game_in_progress !== 1'b0 || score !== s0 || hit_pulse !== 1'b0) begin
      miscompares++; $display("FAIL timer_zero_over: got over %b score %0d pulse %b expected 1 %0d 0", game_over, score, hit_pulse, s0);
    end
    step(1, '0, 100);
    step(0, '0, 100);
    vectors++;
    if (game_in_progress !== 1'b1 || score !== 8'd0 || misses !== 8'd0 || level !== 4'd0) begin
      miscompares++; $display("FAIL restart: got run %b score %0d misses %0d level %0d expected 1 0 0 0", game_in_progress, score, misses, level);
    end
    for (int i = 0; i < 25; i++) step(0, '0, 100);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (dut_pack !== '0) begin
      miscompares++; $display("FAIL async_reset: got %h expected 0", dut_pack);
    end
    model_reset();
    #2 rst = 1'b0;
    step(0, '0, 100);
    vectors++;
    if (dut_pack !== model_pack()) begin
      miscompares++; $display("FAIL after_reset: got %h expected %h", dut_pack, model_pack());
    end
  endtask

  task automatic test_random();
    logic [N-1:0] w;
    bit s;
    int t, r;
    do_reset();
    w = '0;
    for (int i = 0; i < 4000; i++) begin
      s = ($urandom_range(0, 39) == 0);
      t = ($urandom_range(0, 499) == 0) ? 0 : $urandom_range(1, 1000);
      r = $urandom_range(0, 7);
      if (r == 0) w = '0;
      else if (r == 1) w = model_mole();
      else if (r == 2) w = N'($urandom);
      step(s, w, t);
      vectors++;
      if (dut_pack !== model_pack()) begin
        miscompares++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_pack, model_pack());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_mole();
    test_timeout();
    test_hits();
    test_level_floor();
    test_simultaneous();
    test_gameover();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
